// File: rtl/if_stage.sv
// Instruction fetch stage: issues one word fetch at a time, captures the response
// into the IF/ID pipeline register, and handles decode back-pressure and redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_inst_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] hold_q, hold_d;

    logic [31:0] redir_tgt_s;
    logic [31:0] pc_inc_s;
    logic        ifid_free_s;

    assign redir_tgt_s = redirect_pc_i & 32'hFFFF_FFFC;
    assign pc_inc_s    = pc_q + 32'd4;
    assign ifid_free_s = !ifid_valid_q || !stall_i;

    // Next-state, PC, IF/ID and hold-buffer update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_inst_d  = ifid_inst_q;
        // Decode consumes the live entry unless something reloads it below.
        if (ifid_valid_q && !stall_i) begin
            ifid_valid_d = 1'b0;
        end else begin
            ifid_valid_d = ifid_valid_q;
        end

        case (state_q)
            S_FETCH: begin
                // req_q low only in the first cycle out of reset: nothing issued yet.
                if (redirect_i) begin
                    pc_d         = redir_tgt_s;
                    ifid_valid_d = 1'b0;
                    hold_d       = 32'd0;
                    state_d      = req_q ? S_DRAIN : S_FETCH;
                end else begin
                    state_d      = req_q ? S_WAIT : S_FETCH;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d         = redir_tgt_s;
                    ifid_valid_d = 1'b0;
                    hold_d       = 32'd0;
                    state_d      = imem_rvalid_i ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    if (ifid_free_s) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_inst_d  = imem_rdata_i;
                        pc_d         = pc_inc_s;
                        state_d      = S_FETCH;
                    end else begin
                        hold_d       = imem_rdata_i;
                        state_d      = S_HOLD;
                    end
                end else begin
                    state_d      = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_d         = redir_tgt_s;
                    ifid_valid_d = 1'b0;
                    hold_d       = 32'd0;
                    state_d      = S_FETCH;
                end else if (!stall_i) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = pc_q;
                    ifid_inst_d  = hold_q;
                    pc_d         = pc_inc_s;
                    state_d      = S_FETCH;
                end else begin
                    state_d      = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (redirect_i) begin
                    pc_d         = redir_tgt_s;
                    ifid_valid_d = 1'b0;
                    hold_d       = 32'd0;
                end else begin
                    pc_d         = pc_q;
                end
                state_d = imem_rvalid_i ? S_FETCH : S_DRAIN;
            end
            default: begin
                state_d      = S_FETCH;
                ifid_valid_d = 1'b0;
            end
        endcase

        req_d = (state_d == S_FETCH);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_FETCH;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC_ALIGNED;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_inst_q  <= 32'd0;
            hold_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_inst_q  <= ifid_inst_d;
            hold_q       <= hold_d;
        end
    end

    assign imem_req_o   = req_q;
    assign imem_addr_o  = pc_q;
    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_inst_o  = ifid_inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a hand-driven one-cycle memory, back-pressure,
// redirects, PC wrap (second instance) and asynchronous reset.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        req,  d2_req;
    logic [31:0] addr, d2_addr;
    logic        vld,  d2_vld;
    logic [31:0] ipc,  d2_ipc;
    logic [31:0] inst, d2_inst;

    int tests = 0;
    int fails = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .ifid_valid_o(vld), .ifid_pc_o(ipc), .ifid_inst_o(inst)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n),
        .imem_req_o(d2_req), .imem_addr_o(d2_addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .ifid_valid_o(d2_vld), .ifid_pc_o(d2_ipc), .ifid_inst_o(d2_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step(); step();

        // reset values
        check("rst_req",   {31'd0, req}, 32'd0);
        check("rst_vld",   {31'd0, vld}, 32'd0);
        check("rst_ipc",   ipc,  32'd0);
        check("rst_inst",  inst, 32'd0);
        check("rst_addr",  addr, 32'd0);
        check("rst_addr2", d2_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // cycle 0: first request
        step();
        check("c0_req",   {31'd0, req}, 32'd1);
        check("c0_addr",  addr, 32'h0);
        check("c0_addr2", d2_addr, 32'hFFFF_FFFC);
        // cycle 1: WAIT, memory responds
        step();
        check("c1_req", {31'd0, req}, 32'd0);
        check("c1_vld", {31'd0, vld}, 32'd0);
        rvalid = 1'b1; rdata = 32'h0050_0093;
        // cycle 2: IF/ID loaded, next request
        step();
        check("c2_vld",   {31'd0, vld}, 32'd1);
        check("c2_ipc",   ipc,  32'h0);
        check("c2_inst",  inst, 32'h0050_0093);
        check("c2_req",   {31'd0, req}, 32'd1);
        check("c2_addr",  addr, 32'h4);
        check("c2_ipc2",  d2_ipc, 32'hFFFF_FFFC);
        check("c2_addr2", d2_addr, 32'h0000_0000);
        rvalid = 1'b0;
        // entry consumed while waiting for 0x4
        step();
        check("cons_vld", {31'd0, vld}, 32'd0);
        rvalid = 1'b1; rdata = 32'h0010_0113;
        step();
        check("i1_ipc",  ipc,  32'h4);
        check("i1_inst", inst, 32'h0010_0113);
        check("i1_addr", addr, 32'h8);
        rvalid = 1'b0; stall = 1'b1;
        // stalled with IF/ID full; response for 0x8 goes to hold buffer
        step();
        check("st_vld", {31'd0, vld}, 32'd1);
        rvalid = 1'b1; rdata = 32'h0020_0193;
        step();
        check("hold_vld",  {31'd0, vld}, 32'd1);
        check("hold_ipc",  ipc,  32'h4);
        check("hold_inst", inst, 32'h0010_0113);
        check("hold_req",  {31'd0, req}, 32'd0);
        rvalid = 1'b0;
        step();
        check("hold2_ipc", ipc, 32'h4);
        check("hold2_req", {31'd0, req}, 32'd0);
        stall = 1'b0;
        step();
        check("rel_vld",  {31'd0, vld}, 32'd1);
        check("rel_ipc",  ipc,  32'h8);
        check("rel_inst", inst, 32'h0020_0193);
        check("rel_req",  {31'd0, req}, 32'd1);
        check("rel_addr", addr, 32'hC);
        step();
        rvalid = 1'b1; rdata = 32'h0030_0213;
        step();
        check("i3_ipc",  ipc,  32'hC);
        check("i3_addr", addr, 32'h10);
        rvalid = 1'b0;
        // redirect while response for 0x10 outstanding
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        check("drn_vld",  {31'd0, vld}, 32'd0);
        check("drn_req",  {31'd0, req}, 32'd0);
        check("drn_addr", addr, 32'h100);
        redirect = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        check("late_vld",  {31'd0, vld}, 32'd0);
        check("late_req",  {31'd0, req}, 32'd1);
        check("late_addr", addr, 32'h100);
        rvalid = 1'b0;
        step();
        rvalid = 1'b1; rdata = 32'h0040_0293;
        step();
        check("tgt_vld",  {31'd0, vld}, 32'd1);
        check("tgt_ipc",  ipc,  32'h100);
        check("tgt_inst", inst, 32'h0040_0293);
        check("tgt_addr", addr, 32'h104);
        rvalid = 1'b0;
        // redirect coinciding with a response in WAIT
        step();
        rvalid = 1'b1; rdata = 32'hBADB_AD00;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        check("co_req",  {31'd0, req}, 32'd1);
        check("co_addr", addr, 32'h200);
        check("co_vld",  {31'd0, vld}, 32'd0);
        rvalid = 1'b0; redirect = 1'b0;
        step();
        rvalid = 1'b1; rdata = 32'h0050_0313;
        step();
        check("co2_vld",  {31'd0, vld}, 32'd1);
        check("co2_ipc",  ipc,  32'h200);
        check("co2_inst", inst, 32'h0050_0313);
        rvalid = 1'b0; stall = 1'b1;
        // asynchronous reset while in WAIT with IF/ID live
        step();
        check("pre_vld", {31'd0, vld}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vld",  {31'd0, vld}, 32'd0);
        check("ar_req",  {31'd0, req}, 32'd0);
        check("ar_ipc",  ipc,  32'd0);
        check("ar_inst", inst, 32'd0);
        check("ar_addr", addr, 32'd0);
        step();
        rst_n = 1'b1; stall = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        check("ar2_req",  {31'd0, req}, 32'd1);
        check("ar2_addr", addr, 32'd0);
        check("ar2_vld",  {31'd0, vld}, 32'd0);
        rvalid = 1'b0;
        step();
        check("ar3_req", {31'd0, req}, 32'd0);
        check("ar3_vld", {31'd0, vld}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
